hough_axil_master: RTL

- AXI4-Lite initiator that drives the s00_axi_* slave port of the Hough core for the bench-side and SoC-side control path.
- Converts single-beat commands (write, read, poll-until-match) from a simple valid/ready command channel into AXI4-Lite transactions.
- Returns status and read data on a valid/ready response channel.
- Allows one outstanding transaction; owns all five AXI channels on the master side.

---
 rtl/hough_axil_pkg.sv | 25 ++
 rtl/hough_axil_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hough_axil_pkg.sv
// Shared types and constants for the Hough AXI4-Lite control master.
package hough_axil_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_POLL  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_B,
      RD_A,
      RD_D,
      RSP
   } state_e;

endpackage

// File: rtl/hough_axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns write/read/poll commands into AXI beats
// and returns status on a valid/ready response channel. Sticky watchdog flags stalls.
module hough_axil_master
   import hough_axil_pkg::*;
#(
   parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M00_AXI_ADDR_WIDTH = 5,
   parameter int unsigned POLL_MAX             = 1024,
   parameter int unsigned WDOG_CYCLES          = 4096,
   localparam int unsigned DW    = C_M00_AXI_DATA_WIDTH,
   localparam int unsigned AW    = C_M00_AXI_ADDR_WIDTH,
   localparam int unsigned SW    = C_M00_AXI_DATA_WIDTH / 8,
   localparam int unsigned CNT_W = $clog2(POLL_MAX) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [DW-1:0]    cmd_wdata,
   input  logic [SW-1:0]    cmd_wstrb,
   input  logic [DW-1:0]    cmd_mask,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_rdata,
   output logic [1:0]       rsp_resp,
   output logic             rsp_poll_fail,
   output logic [CNT_W-1:0] rsp_poll_cnt,
   output logic             wdog_err,
   output logic [AW-1:0]    m00_axi_awaddr,
   output logic [2:0]       m00_axi_awprot,
   output logic             m00_axi_awvalid,
   input  logic             m00_axi_awready,
   output logic [DW-1:0]    m00_axi_wdata,
   output logic [SW-1:0]    m00_axi_wstrb,
   output logic             m00_axi_wvalid,
   input  logic             m00_axi_wready,
   input  logic [1:0]       m00_axi_bresp,
   input  logic             m00_axi_bvalid,
   output logic             m00_axi_bready,
   output logic [AW-1:0]    m00_axi_araddr,
   output logic [2:0]       m00_axi_arprot,
   output logic             m00_axi_arvalid,
   input  logic             m00_axi_arready,
   input  logic [DW-1:0]    m00_axi_rdata,
   input  logic [1:0]       m00_axi_rresp,
   input  logic             m00_axi_rvalid,
   output logic             m00_axi_rready
);

   localparam int unsigned         WDOG_W   = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDOG_W-1:0]   WDOG_MAX = WDOG_W'(WDOG_CYCLES);
   localparam logic [CNT_W-1:0]    POLL_LIM = CNT_W'(POLL_MAX);

   state_e             state_q, state_d;
   op_e                op_q;
   logic [AW-1:0]      addr_q;
   logic [DW-1:0]      wdata_q, mask_q;
   logic [SW-1:0]      wstrb_q;
   logic               awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
   logic [DW-1:0]      rsp_rdata_q;
   logic [1:0]         rsp_resp_q;
   logic               poll_fail_q;
   logic [CNT_W-1:0]   poll_cnt_q, poll_inc;
   logic               poll_hit, poll_end;
   logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
   logic               wdog_err_q;
   logic               cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, any_fire;

   // Gated with reset so the command channel reads not-ready while held in reset.
   assign cmd_ready = (state_q == IDLE) && rst;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign aw_fire   = awvalid_q && m00_axi_awready;
   assign w_fire    = wvalid_q && m00_axi_wready;
   assign b_fire    = bready_q && m00_axi_bvalid;
   assign ar_fire   = arvalid_q && m00_axi_arready;
   assign r_fire    = rready_q && m00_axi_rvalid;
   assign any_fire  = aw_fire || w_fire || b_fire || ar_fire || r_fire;

   // Next-state decode, including the poll termination test on each returned beat.
   always_comb begin
      state_d  = state_q;
      poll_inc = poll_cnt_q + CNT_W'(1);
      poll_hit = (m00_axi_rdata & mask_q) == (wdata_q & mask_q);
      poll_end = poll_hit || (m00_axi_rresp != RESP_OKAY) || (poll_inc == POLL_LIM);
      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               case (op_e'(cmd_op))
                  OP_WRITE: state_d = WR;
                  OP_READ:  state_d = RD_A;
                  OP_POLL:  state_d = RD_A;
                  default:  state_d = RSP;
               endcase
            end
         end
         WR: begin
            // AW and W retire independently; leave once neither is still pending.
            if ((aw_fire || !awvalid_q) && (w_fire || !wvalid_q)) state_d = WR_B;
         end
         WR_B: if (b_fire) state_d = RSP;
         RD_A: if (ar_fire) state_d = RD_D;
         RD_D: begin
            if (r_fire) begin
               if (op_q != OP_POLL || poll_end) state_d = RSP;
               else                             state_d = RD_A;
            end
         end
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Watchdog counts idle cycles within an AXI phase; any handshake or state change restarts it.
   always_comb begin
      wdog_cnt_d = '0;
      if ((state_q inside {WR, WR_B, RD_A, RD_D}) && (state_d == state_q) && !any_fire) begin
         wdog_cnt_d = (wdog_cnt_q == WDOG_MAX) ? wdog_cnt_q : wdog_cnt_q + WDOG_W'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Command capture on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_WRITE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         mask_q  <= '0;
      end else if (cmd_fire) begin
         op_q    <= op_e'(cmd_op);
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
         mask_q  <= cmd_mask;
      end
   end

   // Registered AXI valids/readies and response valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (cmd_fire && op_e'(cmd_op) == OP_WRITE) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
         end else begin
            if (aw_fire) awvalid_q <= 1'b0;
            if (w_fire)  wvalid_q  <= 1'b0;
         end
         bready_q    <= (state_d == WR_B);
         arvalid_q   <= (state_d == RD_A);
         rready_q    <= (state_d == RD_D);
         rsp_valid_q <= (state_d == RSP);
      end
   end

   // Response payload: cleared on accept, updated by B/R beats, stable while in RSP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
         poll_fail_q <= 1'b0;
         poll_cnt_q  <= '0;
      end else if (cmd_fire) begin
         rsp_rdata_q <= '0;
         rsp_resp_q  <= (op_e'(cmd_op) == OP_RSVD) ? RESP_SLVERR : RESP_OKAY;
         poll_fail_q <= 1'b0;
         poll_cnt_q  <= '0;
      end else if (b_fire) begin
         rsp_resp_q <= m00_axi_bresp;
      end else if (r_fire) begin
         rsp_rdata_q <= m00_axi_rdata;
         rsp_resp_q  <= m00_axi_rresp;
         if (op_q == OP_POLL) begin
            poll_cnt_q  <= poll_inc;
            poll_fail_q <= !poll_hit && (m00_axi_rresp == RESP_OKAY) && (poll_inc == POLL_LIM);
         end
      end
   end

   // Watchdog counter and sticky flag; the transaction itself keeps waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         if (wdog_cnt_d == WDOG_MAX) wdog_err_q <= 1'b1;
      end
   end

   assign m00_axi_awaddr  = addr_q;
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_awvalid = awvalid_q;
   assign m00_axi_wdata   = wdata_q;
   assign m00_axi_wstrb   = wstrb_q;
   assign m00_axi_wvalid  = wvalid_q;
   assign m00_axi_bready  = bready_q;
   assign m00_axi_araddr  = addr_q;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arvalid = arvalid_q;
   assign m00_axi_rready  = rready_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_resp        = rsp_resp_q;
   assign rsp_poll_fail   = poll_fail_q;
   assign rsp_poll_cnt    = poll_cnt_q;
   assign wdog_err        = wdog_err_q;

endmodule
